skintone_result_packer: RTL and testbench

- Sits directly downstream of the skintone datapath.
- Consumes one 8-bit skin score per cycle from the datapath's free-running result stream, which has no backpressure.
- Packs four scores into a 32-bit little-endian word and buffers the words in a first-word-fall-through FIFO.
- Presents the words to the host/DMA side over a valid/ready handshake, with frame-end flush and sticky overflow reporting.

---
 rtl/skintone_result_packer.sv | 142 ++++++++++++++
 tb/tb_skintone_result_packer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/skintone_result_packer.sv
// ---------------------------------------------------------------------------
// skintone_result_packer
//
// Packs the skintone datapath's free-running 8-bit score stream into 32-bit
// little-endian words. The words wait in a first-word-fall-through FIFO until
// the host/DMA side takes them over a valid/ready handshake.
//
// Ports
//   clk             : clock; all logic updates on the rising edge
//   rst             : synchronous, active-high reset
//   score_in_i      : skin score from the datapath
//   score_in_valid_i: score_in_i is valid this cycle (always accepted)
//   flush_i         : one-cycle end-of-frame pulse
//   word_out_o      : FIFO head word; byte 0 (bits [7:0]) is the oldest score
//   word_out_bytes_o: number of valid bytes in word_out_o (1..4)
//   word_out_last_o : head word closes a frame
//   word_out_valid_o: FIFO head is valid
//   word_out_ready_i: consumer accepts the head this cycle
//   fifo_level_o    : number of words currently stored
//   overflow_o      : sticky; set when a word was dropped at full
//
// Handshake: a word transfers on any rising edge where word_out_valid_o and
// word_out_ready_i are both 1. While valid is high and ready is low, the head
// fields hold steady, and valid never drops without a transfer (except on
// rst). When valid is low, ready has no effect.
// ---------------------------------------------------------------------------
module skintone_result_packer #(
  parameter int FIFO_DEPTH = 16,
  parameter int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       score_in_i,
  input  logic             score_in_valid_i,
  input  logic             flush_i,
  output logic [31:0]      word_out_o,
  output logic [2:0]       word_out_bytes_o,
  output logic             word_out_last_o,
  output logic             word_out_valid_o,
  input  logic             word_out_ready_i,
  output logic [LVL_W-1:0] fifo_level_o,
  output logic             overflow_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int ENT_W = 36; // {last, bytes[2:0], word[31:0]}

  // Pack register: up to three pending bytes. Unused lanes are kept at zero.
  logic [23:0]      pack_q, pack_d;
  logic [1:0]       cnt_q, cnt_d;

  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0] level_q, level_d;
  logic             overflow_q;
  logic [ENT_W-1:0] mem_q [FIFO_DEPTH];

  logic [31:0]      word_new;
  logic [2:0]       eff_bytes;
  logic             push, pop, full, accept;
  logic [ENT_W-1:0] head;

  // The candidate word is the pending bytes with the incoming byte (if any)
  // placed in lane [cnt_q].
  always_comb begin
    word_new = {8'h00, pack_q};
    if (score_in_valid_i) begin
      case (cnt_q)
        2'd0:    word_new[7:0]   = score_in_i;
        2'd1:    word_new[15:8]  = score_in_i;
        2'd2:    word_new[23:16] = score_in_i;
        default: word_new[31:24] = score_in_i;
      endcase
    end
  end

  assign eff_bytes = {1'b0, cnt_q} + {2'b00, score_in_valid_i};
  assign push      = (score_in_valid_i && (cnt_q == 2'd3)) ||
                     (flush_i && (eff_bytes != 3'd0));
  assign full      = (level_q == LVL_W'(FIFO_DEPTH));
  assign pop       = word_out_valid_o && word_out_ready_i;
  // At full, a push still fits when the head leaves on the same edge.
  assign accept    = push && (!full || pop);

  always_comb begin
    pack_d = pack_q;
    cnt_d  = cnt_q;
    if (push) begin
      // Even a dropped push clears the pack register.
      pack_d = 24'h0;
      cnt_d  = 2'd0;
    end else if (score_in_valid_i) begin
      pack_d = word_new[23:0];
      cnt_d  = cnt_q + 2'd1;
    end
  end

  always_comb begin
    level_d = level_q;
    case ({accept, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pack_q     <= 24'h0;
      cnt_q      <= 2'd0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      pack_q  <= pack_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      if (accept) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)    rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (push && full && !pop) overflow_q <= 1'b1;
    end
  end

  // Storage needs no reset: entries are only visible through a valid head.
  // At full with a simultaneous pop, the write lands on the slot being
  // vacated, which has already been read combinationally this cycle.
  always_ff @(posedge clk) begin
    if (!rst && accept) begin
      mem_q[wr_ptr_q] <= {flush_i, eff_bytes, word_new};
    end
  end

  // Head fields are gated to zero while empty so the outputs read 0 after reset.
  assign word_out_valid_o = (level_q != '0);
  assign head             = word_out_valid_o ? mem_q[rd_ptr_q] : '0;
  assign word_out_o       = head[31:0];
  assign word_out_bytes_o = head[34:32];
  assign word_out_last_o  = head[35];
  assign fifo_level_o     = level_q;
  assign overflow_o       = overflow_q;

endmodule

// File: tb/tb_skintone_result_packer.sv
// ---------------------------------------------------------------------------
// Directed testbench for skintone_result_packer (FIFO_DEPTH = 16).
// Inputs are driven and outputs sampled 1 ns after each rising edge.
// ---------------------------------------------------------------------------
module tb_skintone_result_packer;

  localparam int DEPTH = 16;
  localparam int LW    = $clog2(DEPTH) + 1;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  always #5 clk = ~clk;

  logic [7:0]    score_in = 8'h0;
  logic          score_in_valid = 1'b0;
  logic          flush = 1'b0;
  logic [31:0]   word_out;
  logic [2:0]    word_out_bytes;
  logic          word_out_last;
  logic          word_out_valid;
  logic          word_out_ready = 1'b0;
  logic [LW-1:0] fifo_level;
  logic          overflow;

  skintone_result_packer #(.FIFO_DEPTH(DEPTH)) dut (
    .clk              (clk),
    .rst              (rst),
    .score_in_i       (score_in),
    .score_in_valid_i (score_in_valid),
    .flush_i          (flush),
    .word_out_o       (word_out),
    .word_out_bytes_o (word_out_bytes),
    .word_out_last_o  (word_out_last),
    .word_out_valid_o (word_out_valid),
    .word_out_ready_i (word_out_ready),
    .fifo_level_o     (fifo_level),
    .overflow_o       (overflow)
  );

  // ---------------- scoreboard ----------------
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] s);
    score_in       = s;
    score_in_valid = 1'b1;
    tick();
    score_in_valid = 1'b0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_word"},  word_out,               32'h0);
    chk({tag, "_bytes"}, {29'h0, word_out_bytes}, 32'h0);
    chk({tag, "_last"},  {31'h0, word_out_last},  32'h0);
    chk({tag, "_valid"}, {31'h0, word_out_valid}, 32'h0);
    chk({tag, "_level"}, 32'(fifo_level),         32'h0);
    chk({tag, "_ovf"},   {31'h0, overflow},       32'h0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [31:0] held_word;
    logic        prev_stall;
    int          got;
    int          budget;

    // Reset
    tick(); tick();
    rst = 1'b0;
    chk_idle("reset");

    // Basic pack with ready=1
    word_out_ready = 1'b1;
    send(8'h11); send(8'h22); send(8'h33);
    chk("basic_not_yet", {31'h0, word_out_valid}, 32'h0);
    send(8'h44);
    chk("basic_valid", {31'h0, word_out_valid}, 32'h1);
    chk("basic_word",  word_out, 32'h44332211);
    chk("basic_bytes", {29'h0, word_out_bytes}, 32'd4);
    chk("basic_last",  {31'h0, word_out_last}, 32'h0);
    chk("basic_level", 32'(fifo_level), 32'd1);
    tick();
    chk("basic_popped_valid", {31'h0, word_out_valid}, 32'h0);
    chk("basic_popped_level", 32'(fifo_level), 32'd0);

    // Partial flush, then a flush with nothing pending
    send(8'hAA); send(8'hBB);
    flush = 1'b1; tick(); flush = 1'b0;
    chk("pflush_valid", {31'h0, word_out_valid}, 32'h1);
    chk("pflush_word",  word_out, 32'h0000BBAA);
    chk("pflush_bytes", {29'h0, word_out_bytes}, 32'd2);
    chk("pflush_last",  {31'h0, word_out_last}, 32'h1);
    flush = 1'b1; tick(); flush = 1'b0;   // head pops here; empty flush adds nothing
    chk("eflush_valid", {31'h0, word_out_valid}, 32'h0);
    chk("eflush_level", 32'(fifo_level), 32'd0);
    tick();
    chk("eflush_valid2", {31'h0, word_out_valid}, 32'h0);

    // Flush coinciding with the fourth score
    send(8'h01); send(8'h02); send(8'h03);
    flush = 1'b1; send(8'h04); flush = 1'b0;
    chk("cflush_word",  word_out, 32'h04030201);
    chk("cflush_bytes", {29'h0, word_out_bytes}, 32'd4);
    chk("cflush_last",  {31'h0, word_out_last}, 32'h1);
    chk("cflush_level", 32'(fifo_level), 32'd1);
    tick();
    chk("cflush_drained", 32'(fifo_level), 32'd0);

    // Overflow: 17 words with ready=0
    word_out_ready = 1'b0;
    for (int w = 0; w < 17; w++) begin
      for (int b = 0; b < 4; b++) send(8'(w * 4 + b));
      if (w == 15) begin
        chk("ovf_level16", 32'(fifo_level), 32'd16);
        chk("ovf_not_yet", {31'h0, overflow}, 32'h0);
      end
    end
    chk("ovf_level_full", 32'(fifo_level), 32'd16);
    chk("ovf_set",        {31'h0, overflow}, 32'h1);
    chk("ovf_head",       word_out, 32'h03020100);
    word_out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("ovf_drain%0d_valid", i), {31'h0, word_out_valid}, 32'h1);
      chk($sformatf("ovf_drain%0d_word", i), word_out,
          {8'(4 * i + 3), 8'(4 * i + 2), 8'(4 * i + 1), 8'(4 * i)});
      tick();
    end
    chk("ovf_empty",  {31'h0, word_out_valid}, 32'h0);
    chk("ovf_sticky", {31'h0, overflow}, 32'h1);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("ovf_cleared", {31'h0, overflow}, 32'h0);

    // Backpressure: 64 scores, random ready, scoreboard checks order
    for (int i = 0; i < 16; i++)
      exp_q.push_back({8'(28 * i + 24), 8'(28 * i + 17), 8'(28 * i + 10), 8'(28 * i + 3)});
    got        = 0;
    prev_stall = 1'b0;
    held_word  = 32'h0;
    budget     = 0;
    while (got < 16 && budget < 400) begin
      if (prev_stall) begin
        chk("bp_hold_valid", {31'h0, word_out_valid}, 32'h1);
        chk("bp_hold_word",  word_out, held_word);
      end
      if (budget < 64) begin
        score_in       = 8'(7 * budget + 3);
        score_in_valid = 1'b1;
      end else begin
        score_in_valid = 1'b0;
      end
      word_out_ready = (budget < 64) ? 1'($urandom_range(0, 1)) : 1'b1;
      if (word_out_valid && word_out_ready) begin
        chk($sformatf("bp_word%0d", got), word_out,
            (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEADBEEF);
        got++;
      end
      prev_stall = word_out_valid && !word_out_ready;
      held_word  = word_out;
      tick();
      budget++;
    end
    score_in_valid = 1'b0;
    chk("bp_count",     32'(got), 32'd16);
    chk("bp_exp_empty", 32'(exp_q.size()), 32'd0);
    chk("bp_overflow",  {31'h0, overflow}, 32'h0);
    tick();
    chk("bp_drained",   32'(fifo_level), 32'd0);

    // Reset mid-operation: 3 words queued, 2 bytes pending
    word_out_ready = 1'b0;
    for (int i = 0; i < 14; i++) send(8'(8'h80 + i));
    chk("rmid_level", 32'(fifo_level), 32'd3);
    rst = 1'b1; tick(); rst = 1'b0;
    chk_idle("rmid");
    word_out_ready = 1'b1;
    send(8'hC1); send(8'hC2); send(8'hC3); send(8'hC4);
    chk("rmid_word",  word_out, 32'hC4C3C2C1);
    chk("rmid_bytes", {29'h0, word_out_bytes}, 32'd4);
    chk("rmid_level_after", 32'(fifo_level), 32'd1);
    tick();

    // ---------------- final report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
